// File: rtl/demux_sched_if.sv
// rtl/demux_sched_if.sv - handshake and output bundle for the demux scheduler
// The source/sink side uses master; the scheduler uses slave.
interface demux_sched_if;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic [3:0] out_ready;
  logic [3:0] x;
  logic [3:0] x_valid;
  logic [1:0] sel;
  logic       frame_done;
  logic       stall_err;

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, x, x_valid, sel, frame_done, stall_err
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, x, x_valid, sel, frame_done, stall_err
  );
endinterface

// File: rtl/demux_sched.sv
// rtl/demux_sched.sv - round-robin 1-to-4 serial bit demux with stall detection
// DEMUX_SCHED_SKIP_EN: work-conserving grant; undefined: strict order g = ptr.
module demux_sched (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_n,
  demux_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] xfer_cnt_q, xfer_cnt_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] stall_cnt_q, stall_cnt_d;
  logic [3:0] x_q, x_d;
  logic [3:0] x_valid_q, x_valid_d;
  logic       frame_done_q, frame_done_d;
  logic       stall_err_q, stall_err_d;

  logic [1:0] grant;
  logic       grant_ok;
  logic       xfer;

`ifdef DEMUX_SCHED_SKIP_EN
  logic [1:0] cand;

  // Scan farthest offset first so the nearest ready channel wins.
  always_comb begin
    grant    = ptr_q;
    grant_ok = 1'b0;
    cand     = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (bus.out_ready[cand]) begin
        grant    = cand;
        grant_ok = 1'b1;
      end
    end
  end
`else
  always_comb begin
    grant    = ptr_q;
    grant_ok = bus.out_ready[ptr_q];
  end
`endif

  // Gating on en_n keeps a disabling edge from ever accepting a bit.
  assign bus.in_ready = (state_q == RUN) && !en_n && grant_ok;
  assign xfer         = bus.in_ready && bus.in_valid;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    xfer_cnt_d   = xfer_cnt_q;
    sel_d        = sel_q;
    stall_cnt_d  = stall_cnt_q;
    stall_err_d  = stall_err_q;
    x_d          = 4'b0000;
    x_valid_d    = 4'b0000;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!en_n) begin
          state_d     = RUN;
          ptr_d       = 2'd0;
          xfer_cnt_d  = 2'd0;
          stall_cnt_d = 4'd0;
        end
      end
      RUN: begin
        if (en_n) begin
          state_d     = IDLE;
          ptr_d       = 2'd0;
          xfer_cnt_d  = 2'd0;
          stall_cnt_d = 4'd0;
          stall_err_d = 1'b0;
        end else begin
          if (xfer) begin
            x_d          = 4'(bus.in_bit) << grant;
            x_valid_d    = 4'b0001 << grant;
            sel_d        = grant;
            ptr_d        = grant + 2'd1;
            xfer_cnt_d   = xfer_cnt_q + 2'd1;
            frame_done_d = (xfer_cnt_q == 2'd3);
          end
          if (bus.in_valid && !bus.in_ready) begin
            stall_cnt_d = stall_cnt_q + 4'd1;
            if (stall_cnt_q == 4'd14) begin
              state_d     = STALL;
              stall_err_d = 1'b1;
            end
          end else begin
            stall_cnt_d = 4'd0;
          end
        end
      end
      STALL: begin
        if (en_n) begin
          state_d     = IDLE;
          ptr_d       = 2'd0;
          xfer_cnt_d  = 2'd0;
          stall_cnt_d = 4'd0;
          stall_err_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= 2'd0;
      xfer_cnt_q   <= 2'd0;
      sel_q        <= 2'd0;
      stall_cnt_q  <= 4'd0;
      stall_err_q  <= 1'b0;
      x_q          <= 4'b0000;
      x_valid_q    <= 4'b0000;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      xfer_cnt_q   <= xfer_cnt_d;
      sel_q        <= sel_d;
      stall_cnt_q  <= stall_cnt_d;
      stall_err_q  <= stall_err_d;
      x_q          <= x_d;
      x_valid_q    <= x_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.x          = x_q;
  assign bus.x_valid    = x_valid_q;
  assign bus.sel        = sel_q;
  assign bus.frame_done = frame_done_q;
  assign bus.stall_err  = stall_err_q;

endmodule

// File: tb/tb_demux_sched.sv
// tb/tb_demux_sched.sv - directed self-checking bench for demux_sched
module tb_demux_sched;

  logic clk = 1'b0;
  logic rst;
  logic en_n;

  demux_sched_if bus ();

  demux_sched dut (
    .clk  (clk),
    .rst  (rst),
    .en_n (en_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    en_n          = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 4'b0000;
    step;
    step;
    chk("rst_x_valid", bus.x_valid, 4'b0000);
    chk("rst_x", bus.x, 4'b0000);
    chk("rst_sel", {2'b00, bus.sel}, 4'd0);
    chk("rst_frame_done", {3'b000, bus.frame_done}, 4'd0);
    chk("rst_stall_err", {3'b000, bus.stall_err}, 4'd0);
    bus.out_ready = 4'hF;
    en_n          = 1'b0;
    #1;
    chk("rst_in_ready", {3'b000, bus.in_ready}, 4'd0);
    en_n = 1'b1;
    rst  = 1'b0;
    step;
    chk("idle_in_ready", {3'b000, bus.in_ready}, 4'd0);

    // Full-ready frame: bits 1,0,1,1 to channels 0..3
    en_n = 1'b0;
    step;
    chk("run_in_ready", {3'b000, bus.in_ready}, 4'd1);
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    step;
    chk("f1_x_valid", bus.x_valid, 4'b0001);
    chk("f1_x", bus.x, 4'b0001);
    chk("f1_sel", {2'b00, bus.sel}, 4'd0);
    chk("f1_frame_done", {3'b000, bus.frame_done}, 4'd0);
    bus.in_bit = 1'b0;
    step;
    chk("f2_x_valid", bus.x_valid, 4'b0010);
    chk("f2_x", bus.x, 4'b0000);
    chk("f2_sel", {2'b00, bus.sel}, 4'd1);
    bus.in_bit = 1'b1;
    step;
    chk("f3_x_valid", bus.x_valid, 4'b0100);
    chk("f3_x", bus.x, 4'b0100);
    chk("f3_frame_done", {3'b000, bus.frame_done}, 4'd0);
    step;
    chk("f4_x_valid", bus.x_valid, 4'b1000);
    chk("f4_x", bus.x, 4'b1000);
    chk("f4_sel", {2'b00, bus.sel}, 4'd3);
    chk("f4_frame_done", {3'b000, bus.frame_done}, 4'd1);
    bus.in_valid = 1'b0;
    step;
    chk("f5_x_valid", bus.x_valid, 4'b0000);
    chk("f5_frame_done", {3'b000, bus.frame_done}, 4'd0);
    chk("f5_sel_hold", {2'b00, bus.sel}, 4'd3);

    // Partial ready 1011: skip channel 2 or wait on it
    en_n = 1'b1;
    step;
    en_n = 1'b0;
    step;
    bus.out_ready = 4'b1011;
    bus.in_valid  = 1'b1;
    bus.in_bit    = 1'b1;
    step;
    chk("p1_x_valid", bus.x_valid, 4'b0001);
    step;
    chk("p2_x_valid", bus.x_valid, 4'b0010);
`ifdef DEMUX_SCHED_SKIP_EN
    step;
    chk("p3_x_valid", bus.x_valid, 4'b1000);
    chk("p3_sel", {2'b00, bus.sel}, 4'd3);
    step;
    chk("p4_x_valid", bus.x_valid, 4'b0001);
    chk("p4_frame_done", {3'b000, bus.frame_done}, 4'd1);
`else
    chk("p3_in_ready", {3'b000, bus.in_ready}, 4'd0);
    step;
    chk("p3_x_valid", bus.x_valid, 4'b0000);
    chk("p3_sel_hold", {2'b00, bus.sel}, 4'd1);
`endif
    bus.in_valid = 1'b0;
    step;

    // Stall: 15 cycles with no ready channel
    en_n = 1'b1;
    step;
    en_n = 1'b0;
    step;
    bus.out_ready = 4'b0000;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 14; i++) step;
    chk("s14_stall_err", {3'b000, bus.stall_err}, 4'd0);
    step;
    chk("s15_stall_err", {3'b000, bus.stall_err}, 4'd1);
    bus.out_ready = 4'hF;
    #1;
    chk("stall_in_ready", {3'b000, bus.in_ready}, 4'd0);
    step;
    chk("stall_x_valid", bus.x_valid, 4'b0000);
    chk("stall_sticky", {3'b000, bus.stall_err}, 4'd1);
    en_n = 1'b1;
    step;
    chk("stall_clear", {3'b000, bus.stall_err}, 4'd0);
    chk("stall_idle_in_ready", {3'b000, bus.in_ready}, 4'd0);
    bus.in_valid = 1'b0;

    // Disable on a would-be transfer edge
    en_n = 1'b0;
    step;
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    step;
    chk("d1_x_valid", bus.x_valid, 4'b0001);
    en_n = 1'b1;
    #1;
    chk("d_in_ready", {3'b000, bus.in_ready}, 4'd0);
    step;
    chk("d2_x_valid", bus.x_valid, 4'b0000);
    chk("d2_x", bus.x, 4'b0000);
    en_n = 1'b0;
    step;
    chk("d3_in_ready", {3'b000, bus.in_ready}, 4'd1);
    step;
    chk("d4_x_valid", bus.x_valid, 4'b0001);
    chk("d4_sel", {2'b00, bus.sel}, 4'd0);
    step;
    chk("d5_x_valid", bus.x_valid, 4'b0010);

    // Async reset mid-frame (two transfers counted)
    #2;
    rst = 1'b1;
    #1;
    chk("ar_x_valid", bus.x_valid, 4'b0000);
    chk("ar_x", bus.x, 4'b0000);
    chk("ar_in_ready", {3'b000, bus.in_ready}, 4'd0);
    chk("ar_sel", {2'b00, bus.sel}, 4'd0);
    bus.in_valid = 1'b0;
    step;
    rst = 1'b0;
    step;
    bus.in_valid = 1'b1;
    step;
    chk("r1_x_valid", bus.x_valid, 4'b0001);
    chk("r1_frame_done", {3'b000, bus.frame_done}, 4'd0);
    step;
    chk("r2_frame_done", {3'b000, bus.frame_done}, 4'd0);
    step;
    chk("r3_x_valid", bus.x_valid, 4'b0100);
    chk("r3_frame_done", {3'b000, bus.frame_done}, 4'd0);
    step;
    chk("r4_x_valid", bus.x_valid, 4'b1000);
    chk("r4_frame_done", {3'b000, bus.frame_done}, 4'd1);
    bus.in_valid = 1'b0;
    step;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_sched.md
DEMUX_SCHED -- requirements
Module: demux_sched

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port en_n, input, 1 bit: active-low enable; 1 = disabled, outputs forced to zero.
REQ-004 SHALL have port in_valid, input, 1 bit: source presents a bit on in_bit.
REQ-005 SHALL have port in_bit, input, 1 bit: serial data bit to distribute.
REQ-006 SHALL have port in_ready, output, 1 bit: scheduler accepts in_bit this cycle.
REQ-007 SHALL have port out_ready, input, 4 bits: per-channel sink ready; bit i belongs to channel i.
REQ-008 SHALL have port x, output, 4 bits, registered: demuxed data; only the granted channel bit may be nonzero.
REQ-009 SHALL have port x_valid, output, 4 bits, registered: one-hot strobe marking the channel written; zero when idle.
REQ-010 SHALL have port sel, output, 2 bits, registered: index of the last granted channel.
REQ-011 SHALL have port frame_done, output, 1 bit, registered: one-cycle pulse after every 4th transfer.
REQ-012 SHALL have port stall_err, output, 1 bit, registered: sticky stall flag.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and STALL.
REQ-014 IDLE SHALL hold in_ready=0, x=0, x_valid=0 and frame_done=0; en_n=0 SHALL move the FSM to RUN on the next edge with ptr=0 and xfer_cnt=0.
REQ-015 RUN SHALL compute grant g combinationally: the first channel in round-robin order ptr, ptr+1, ... (mod 4) with out_ready[g]=1.
REQ-016 RUN SHALL drive in_ready=1 when a grant exists, and 0 otherwise.
REQ-017 A transfer SHALL occur when in_valid=1, in_ready=1 and state=RUN.
REQ-018 On a transfer, the next cycle SHALL have x = in_bit at bit g (others 0), x_valid = one-hot g, sel = g, and ptr = (g+1) mod 4; latency is exactly 1 cycle.
REQ-019 On any cycle without a transfer, the next cycle SHALL have x=0 and x_valid=0; sel and ptr SHALL hold.
REQ-020 The 2-bit xfer_cnt SHALL increment on each transfer and wrap from 3 to 0; frame_done SHALL pulse together with the x_valid of the transfer that wraps it.
REQ-021 The 4-bit stall counter SHALL increment each RUN cycle with in_valid=1 and in_ready=0, and clear on any other RUN cycle.
REQ-022 When the stall counter reaches 15, the FSM SHALL enter STALL and set stall_err=1.
REQ-023 STALL SHALL hold in_ready=0, x=0 and x_valid=0; stall_err SHALL stay 1 until en_n=1.
REQ-024 en_n=1 in RUN or STALL SHALL return the FSM to IDLE on the next edge; a transfer sampled on that same edge SHALL be discarded (x_valid=0), and stall_err, ptr and xfer_cnt SHALL clear.
REQ-025 An out_ready change in the same cycle as a transfer SHALL use the sampled value of that cycle only; there SHALL be no lookahead.

Reset
REQ-026 rst=1 SHALL asynchronously force: state=IDLE, ptr=0, xfer_cnt=0, stall counter=0, x=0, x_valid=0, sel=0, frame_done=0, stall_err=0.
REQ-027 While rst=1, in_ready SHALL be 0.
REQ-028 After rst deasserts, the block SHALL leave IDLE only via REQ-014.
REQ-029 rst asserted mid-transfer SHALL drop that transfer.

Configuration
REQ-030 Macro DEMUX_SCHED_SKIP_EN defined: the grant SHALL follow REQ-015 (work-conserving; not-ready channels are skipped).
REQ-031 Macro DEMUX_SCHED_SKIP_EN undefined: the grant SHALL be strict order, g=ptr only; in_ready=out_ready[ptr] in RUN; the stall rules of REQ-021 and REQ-022 are unchanged.

Verification
REQ-032 All out_ready=4'hF, en_n=0, in_valid=1, bits 1,0,1,1 -> x_valid 0001, 0010, 0100, 1000 and x 0001, 0000, 0100, 1000, each one cycle after acceptance; frame_done pulses with the 4th.
REQ-033 out_ready=4'b1011 with SKIP_EN, 4 bits of 1 -> grants 0, 1, 3, 0; without SKIP_EN -> grants 0, 1, then in_ready=0 waiting on channel 2.
REQ-034 out_ready=0, in_valid=1 for 15 cycles -> STALL, stall_err=1 on the next cycle; en_n=1 -> IDLE, stall_err=0.
REQ-035 en_n rises on the same edge as a transfer -> x_valid stays 0 and the FSM goes to IDLE; after en_n=0 the first grant is channel 0.
REQ-036 rst pulse mid-frame (xfer_cnt=2) -> all outputs 0 immediately, without waiting for a clock edge; the next frame_done comes after 4 fresh transfers.
